// File: rtl/ahb_bus_matrix_pkg.sv
// Shared AHB definitions for the bus-matrix output-stage arbiter.
// HTRANS / HBURST codes and the burst-length helper.
package ahb_bus_matrix_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    // Beats still to come after the NONSEQ of a fixed-length burst.
    function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
        logic [3:0] beats;
        beats = 4'd0;
        case (hburst)
            HBURST_WRAP4,
            HBURST_INCR4:  beats = 4'd3;
            HBURST_WRAP8,
            HBURST_INCR8:  beats = 4'd7;
            HBURST_WRAP16,
            HBURST_INCR16: beats = 4'd15;
            default:       beats = 4'd0;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/ahb_bus_matrix_rr_pick.sv
// Combinational round-robin picker: first requester after 'last',
// wrapping modulo NUM_IN; 'none' when nobody requests.
module ahb_bus_matrix_rr_pick #(
    parameter int NUM_IN = 3,
    parameter int IDX_W  = 2
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [IDX_W-1:0]  last,
    output logic [IDX_W-1:0]  idx,
    output logic              none
);

    // Scan from furthest to nearest so the nearest requester wins.
    always_comb begin
        logic [IDX_W-1:0] cand;
        idx  = last;
        none = 1'b1;
        cand = '0;
        for (int k = NUM_IN; k >= 1; k--) begin
            cand = IDX_W'((int'(last) + k) % NUM_IN);
            if (req[cand]) begin
                idx  = cand;
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ahb_bus_matrix_arbiter_mi.sv
// Round-robin arbiter for one bus-matrix output stage; holds the grant
// through bursts and locked sequences, tracks the data-phase owner.
module ahb_bus_matrix_arbiter_mi
    import ahb_bus_matrix_pkg::*;
#(
    parameter int NUM_IN = 3,
    parameter int IDX_W  = 2
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic [NUM_IN-1:0]     req_in,
    input  logic [2*NUM_IN-1:0]   trans_in,
    input  logic [3*NUM_IN-1:0]   burst_in,
    input  logic [NUM_IN-1:0]     mastlock_in,
    input  logic                  HREADYM,
    output logic [IDX_W-1:0]      addr_in_port,
    output logic                  no_port,
    output logic [IDX_W-1:0]      data_in_port,
    output logic                  data_valid,
    output logic [NUM_IN-1:0]     active_in
);

    logic [IDX_W-1:0] grant_reg;
    logic             no_port_reg;
    logic [3:0]       beat_cnt;
    logic             hold_lock;

    logic [1:0]       trans_a [NUM_IN];
    logic [2:0]       burst_a [NUM_IN];

    for (genvar i = 0; i < NUM_IN; i++) begin : g_unpack
        assign trans_a[i] = trans_in[2*i +: 2];
        assign burst_a[i] = burst_in[3*i +: 3];
    end

    logic [1:0]       own_trans;
    logic             own_cont;
    logic             own_term;
    logic             hold;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_none;
    logic [IDX_W-1:0] next_grant;
    logic             next_no_port;

    ahb_bus_matrix_rr_pick #(
        .NUM_IN (NUM_IN),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req  (req_in),
        .last (grant_reg),
        .idx  (pick_idx),
        .none (pick_none)
    );

    assign own_trans = trans_a[grant_reg];
    assign own_cont  = (own_trans == HTRANS_SEQ) ||
                       (own_trans == HTRANS_BUSY);
    // IDLE/NONSEQ from the owner ends any burst early.
    assign own_term  = (own_trans == HTRANS_IDLE) ||
                       (own_trans == HTRANS_NONSEQ);

    assign hold = !no_port_reg &&
                  (hold_lock || own_cont ||
                   ((beat_cnt != 4'd0) && !own_term));

    always_comb begin
        next_grant   = grant_reg;
        next_no_port = 1'b1;
        if (hold) begin
            next_grant   = grant_reg;
            next_no_port = 1'b0;
        end else if (!pick_none) begin
            next_grant   = pick_idx;
            next_no_port = 1'b0;
        end
    end

    // A stalled transfer freezes the selection.
    assign addr_in_port = HREADYM ? next_grant   : grant_reg;
    assign no_port      = HREADYM ? next_no_port : no_port_reg;

    always_comb begin
        active_in = '0;
        if (!no_port) begin
            active_in[addr_in_port] = 1'b1;
        end
    end

    logic [1:0] addr_trans;
    logic [2:0] addr_burst;
    logic       addr_lock;

    assign addr_trans = trans_a[addr_in_port];
    assign addr_burst = burst_a[addr_in_port];
    assign addr_lock  = mastlock_in[addr_in_port];

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            grant_reg    <= IDX_W'(NUM_IN - 1);
            no_port_reg  <= 1'b1;
            beat_cnt     <= 4'd0;
            hold_lock    <= 1'b0;
            data_in_port <= '0;
            data_valid   <= 1'b0;
        end else if (HREADYM) begin
            grant_reg    <= next_grant;
            no_port_reg  <= next_no_port;
            data_in_port <= addr_in_port;
            data_valid   <= !no_port;
            if (no_port) begin
                beat_cnt  <= 4'd0;
                hold_lock <= 1'b0;
            end else begin
                case (addr_trans)
                    HTRANS_NONSEQ: beat_cnt <= burst_beats(addr_burst);
                    HTRANS_SEQ: begin
                        if (beat_cnt != 4'd0) begin
                            beat_cnt <= beat_cnt - 4'd1;
                        end
                    end
                    HTRANS_IDLE:   beat_cnt <= 4'd0;
                    default:       beat_cnt <= beat_cnt;
                endcase
                if (!addr_lock) begin
                    hold_lock <= 1'b0;
                end else if (addr_trans != HTRANS_IDLE) begin
                    hold_lock <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_bus_matrix_arbiter_mi.sv
// Bench for ahb_bus_matrix_arbiter_mi: directed vector table followed
// by randomized traffic against a behavioural arbitration model.
module tb_ahb_bus_matrix_arbiter_mi;

    localparam int N = 3;
    localparam int IW = 2;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic [N-1:0]  req_in;
    logic [2*N-1:0] trans_in;
    logic [3*N-1:0] burst_in;
    logic [N-1:0]  mastlock_in;
    logic          HREADYM;
    logic [IW-1:0] addr_in_port;
    logic          no_port;
    logic [IW-1:0] data_in_port;
    logic          data_valid;
    logic [N-1:0]  active_in;

    ahb_bus_matrix_arbiter_mi #(.NUM_IN(N), .IDX_W(IW)) dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .req_in       (req_in),
        .trans_in     (trans_in),
        .burst_in     (burst_in),
        .mastlock_in  (mastlock_in),
        .HREADYM      (HREADYM),
        .addr_in_port (addr_in_port),
        .no_port      (no_port),
        .data_in_port (data_in_port),
        .data_valid   (data_valid),
        .active_in    (active_in)
    );

    always #5 HCLK = ~HCLK;

    int errors = 0;
    int checks = 0;

    localparam int TI = 0, TB = 1, TN = 2, TS = 3;

    typedef struct {
        logic       rst;
        logic       rdy;
        int         t [3];
        int         b [3];
        logic [2:0] lk;
        int         e_addr;
        logic       e_nop;
        int         e_dport;
        logic       e_dval;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic rdy,
                                int t0, int t1, int t2,
                                int b0, int b1, int b2,
                                logic [2:0] lk,
                                int ea, logic en, int ed, logic ev);
        vec_t v;
        v.rst = rst; v.rdy = rdy;
        v.t[0] = t0; v.t[1] = t1; v.t[2] = t2;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2;
        v.lk = lk;
        v.e_addr = ea; v.e_nop = en; v.e_dport = ed; v.e_dval = ev;
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic drive(logic rst, logic rdy, int t[3], int b[3],
                         logic [2:0] lk);
        HRESET  = rst;
        HREADYM = rdy;
        for (int i = 0; i < N; i++) begin
            trans_in[2*i +: 2] = 2'(t[i]);
            burst_in[3*i +: 3] = 3'(b[i]);
            req_in[i] = (t[i] != TI);
        end
        mastlock_in = lk;
    endtask

    task automatic check_outs(string tag, int ea, logic en,
                              int ed, logic ev);
        logic [N-1:0] eact;
        eact = '0;
        if (!en) eact[ea] = 1'b1;
        chk({tag, ".addr"}, int'(addr_in_port), ea);
        chk({tag, ".no_port"}, int'(no_port), int'(en));
        chk({tag, ".active"}, int'(active_in), int'(eact));
        chk({tag, ".dport"}, int'(data_in_port), ed);
        chk({tag, ".dvalid"}, int'(data_valid), int'(ev));
    endtask

    // Behavioural model: owner index, outstanding beats, lock flag.
    int   m_last;
    bit   m_none;
    int   m_beats;
    bit   m_lock;
    int   m_dport;
    bit   m_dval;
    int   e_addr;
    bit   e_none;
    int   beats_of [8] = '{0, 0, 3, 3, 7, 7, 15, 15};

    function automatic void model_comb(bit rdy, int t[3]);
        int  ot;
        bit  keep;
        ot = t[m_last];
        keep = !m_none &&
               (m_lock || ot == TS || ot == TB ||
                (m_beats > 0 && ot != TI && ot != TN));
        if (!rdy) begin
            e_addr = m_last;
            e_none = m_none;
        end else if (keep) begin
            e_addr = m_last;
            e_none = 0;
        end else begin
            e_addr = m_last;
            e_none = 1;
            for (int k = N; k >= 1; k--) begin
                if (t[(m_last + k) % N] != TI) begin
                    e_addr = (m_last + k) % N;
                    e_none = 0;
                end
            end
        end
    endfunction

    function automatic void model_seq(bit rst, bit rdy, int t[3],
                                      int b[3], logic [2:0] lk);
        int at;
        if (rst) begin
            m_last = N - 1; m_none = 1; m_beats = 0; m_lock = 0;
            m_dport = 0; m_dval = 0;
        end else if (rdy) begin
            m_dport = e_addr;
            m_dval  = !e_none;
            m_last  = e_addr;
            m_none  = e_none;
            if (e_none) begin
                m_beats = 0;
                m_lock  = 0;
            end else begin
                at = t[e_addr];
                if (at == TN) m_beats = beats_of[b[e_addr]];
                else if (at == TS && m_beats > 0) m_beats--;
                else if (at == TI) m_beats = 0;
                if (!lk[e_addr]) m_lock = 0;
                else if (at != TI) m_lock = 1;
            end
        end
    endfunction

    initial begin
        int t[3];
        int b[3];
        int z[3];
        logic r, y;
        logic [2:0] lk;
        z = '{0, 0, 0};

        // reset / idle
        vecs.push_back(mk(0,1, TI,TI,TI, 0,0,0, 3'b000, 2,1,0,0));
        vecs.push_back(mk(0,1, TI,TI,TI, 0,0,0, 3'b000, 2,1,2,0));
        // all request single transfers: 0,1,2,0,1,2
        vecs.push_back(mk(0,1, TN,TN,TN, 0,0,0, 3'b000, 0,0,2,0));
        vecs.push_back(mk(0,1, TN,TN,TN, 0,0,0, 3'b000, 1,0,0,1));
        vecs.push_back(mk(0,1, TN,TN,TN, 0,0,0, 3'b000, 2,0,1,1));
        vecs.push_back(mk(0,1, TN,TN,TN, 0,0,0, 3'b000, 0,0,2,1));
        vecs.push_back(mk(0,1, TN,TN,TN, 0,0,0, 3'b000, 1,0,0,1));
        vecs.push_back(mk(0,1, TN,TN,TN, 0,0,0, 3'b000, 2,0,1,1));
        // input 1 INCR4 while 0 and 2 compete
        vecs.push_back(mk(0,1, TI,TN,TI, 0,3,0, 3'b000, 1,0,2,1));
        vecs.push_back(mk(0,1, TN,TS,TN, 0,3,0, 3'b000, 1,0,1,1));
        vecs.push_back(mk(0,1, TN,TS,TN, 0,3,0, 3'b000, 1,0,1,1));
        vecs.push_back(mk(0,1, TN,TS,TN, 0,3,0, 3'b000, 1,0,1,1));
        vecs.push_back(mk(0,1, TN,TI,TN, 0,0,0, 3'b000, 2,0,1,1));
        // stall during input 0 transfer, input 2 raises request
        vecs.push_back(mk(0,1, TN,TI,TI, 0,0,0, 3'b000, 0,0,2,1));
        vecs.push_back(mk(0,0, TN,TI,TN, 0,0,0, 3'b000, 0,0,0,1));
        vecs.push_back(mk(0,0, TN,TI,TN, 0,0,0, 3'b000, 0,0,0,1));
        vecs.push_back(mk(0,0, TN,TI,TN, 0,0,0, 3'b000, 0,0,0,1));
        vecs.push_back(mk(0,1, TN,TI,TN, 0,0,0, 3'b000, 2,0,0,1));
        // locked sequence on input 2
        vecs.push_back(mk(0,1, TI,TI,TN, 0,0,0, 3'b100, 2,0,2,1));
        vecs.push_back(mk(0,1, TN,TN,TN, 0,0,0, 3'b100, 2,0,2,1));
        vecs.push_back(mk(0,1, TN,TN,TI, 0,0,0, 3'b100, 2,0,2,1));
        vecs.push_back(mk(0,1, TN,TN,TI, 0,0,0, 3'b000, 2,0,2,1));
        vecs.push_back(mk(0,1, TN,TN,TI, 0,0,0, 3'b000, 0,0,2,1));
        // reset in the middle of an INCR8 from input 0
        vecs.push_back(mk(0,1, TN,TI,TI, 5,0,0, 3'b000, 0,0,0,1));
        vecs.push_back(mk(0,1, TS,TI,TI, 5,0,0, 3'b000, 0,0,0,1));
        vecs.push_back(mk(0,1, TS,TI,TI, 5,0,0, 3'b000, 0,0,0,1));
        vecs.push_back(mk(1,1, TS,TI,TI, 5,0,0, 3'b000, 0,0,0,1));
        vecs.push_back(mk(0,1, TI,TI,TI, 0,0,0, 3'b000, 2,1,0,0));
        vecs.push_back(mk(0,1, TN,TI,TI, 0,0,0, 3'b000, 0,0,2,0));
        vecs.push_back(mk(0,1, TI,TN,TI, 0,0,0, 3'b000, 1,0,0,1));

        drive(1, 1, z, z, 3'b000);
        repeat (2) @(posedge HCLK);
        #1;
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].rdy, vecs[i].t, vecs[i].b,
                  vecs[i].lk);
            #4;
            check_outs($sformatf("vec%0d", i), vecs[i].e_addr,
                       vecs[i].e_nop, vecs[i].e_dport, vecs[i].e_dval);
            @(posedge HCLK);
            #1;
        end

        // randomized traffic against the model
        drive(1, 1, z, z, 3'b000);
        model_seq(1, 1, z, z, 3'b000);
        @(posedge HCLK);
        #1;
        for (int c = 0; c < 800; c++) begin
            r = ($urandom_range(0, 59) == 0);
            y = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                t[i] = int'($urandom_range(0, 3));
                b[i] = int'($urandom_range(0, 7));
                lk[i] = ($urandom_range(0, 5) == 0);
            end
            drive(r, y, t, b, lk);
            #4;
            model_comb(y, t);
            check_outs($sformatf("rnd%0d", c), e_addr, e_none,
                       m_dport, m_dval);
            @(posedge HCLK);
            model_seq(r, y, t, b, lk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
